// File: rtl/fetch_unit_if.sv
// ---------------------------------------------------------------------------
// fetch_unit_if
// Bundles the fetch stage's control, memory-bus and decode-side handshake
// signals.
//   master : the environment around the fetch stage (PC source, memory
//            arbiter, decode). It drives requests and memory data, and it
//            receives address, instruction and status.
//   slave  : the fetch stage itself.
// Signals:
//   en, flush, pc          control from the PC / pipeline control
//   data_in, mem_ready     memory read data and its qualifier
//   inst_ack               decode accepts inst_out
//   addr, mem_req          memory read address and request
//   inst_out, inst_valid   instruction toward decode
//   busy                   a memory fill is in progress
// ---------------------------------------------------------------------------
interface fetch_unit_if #(
  parameter int M_WIDTH    = 8,
  parameter int INST_WIDTH = 16
);
  logic                  en;
  logic                  flush;
  logic [M_WIDTH-1:0]    pc;
  logic [M_WIDTH-1:0]    data_in;
  logic                  mem_ready;
  logic                  inst_ack;
  logic [M_WIDTH-1:0]    addr;
  logic                  mem_req;
  logic [INST_WIDTH-1:0] inst_out;
  logic                  inst_valid;
  logic                  busy;

  modport master (
    output en, flush, pc, data_in, mem_ready, inst_ack,
    input  addr, mem_req, inst_out, inst_valid, busy
  );

  modport slave (
    input  en, flush, pc, data_in, mem_ready, inst_ack,
    output addr, mem_req, inst_out, inst_valid, busy
  );
endinterface

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
// Instruction fetch stage with a direct-mapped instruction cache. A lookup
// on pc either hits and presents the cached line, or misses and fills the
// line from memory in BEATS = INST_WIDTH/M_WIDTH narrow reads (beat 0 is the
// least significant slice). The instruction is then held for decode until
// it is acknowledged.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous, active-high reset
//   bus  fetch_unit_if.slave: en, flush, pc, data_in, mem_ready, inst_ack in;
//        addr, mem_req, inst_out, inst_valid, busy out
// Parameters:
//   M_WIDTH     address / memory data width
//   INST_WIDTH  instruction width, an integer multiple of M_WIDTH
//   CELL_CNT    number of cache lines, a power of two and at least 2
// ---------------------------------------------------------------------------
module fetch_unit #(
  parameter int M_WIDTH    = 8,
  parameter int INST_WIDTH = 16,
  parameter int CELL_CNT   = 8
) (
  input  logic        clk,
  input  logic        rst,
  fetch_unit_if.slave bus
);

  localparam int BEATS  = INST_WIDTH / M_WIDTH;
  localparam int IDX    = $clog2(CELL_CNT);
  localparam int TAG_W  = M_WIDTH - IDX;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BEATS - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_FILL  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]            state_q,  state_d;
  logic [BEAT_W-1:0]     beat_q,   beat_d;
  logic [INST_WIDTH-1:0] inst_q,   inst_d;
  logic [M_WIDTH-1:0]    pc_l_q,   pc_l_d;
  logic [CELL_CNT-1:0]   valid_q,  valid_d;

  // Tag and data storage carry no reset; the valid bits alone decide
  // whether a line may be used.
  logic [TAG_W-1:0]      tag_mem  [CELL_CNT];
  logic [INST_WIDTH-1:0] data_mem [CELL_CNT];

  logic [IDX-1:0]        look_idx;
  logic [TAG_W-1:0]      look_tag;
  logic                  look_hit;
  logic [IDX-1:0]        fill_idx;
  logic                  wr_en;
  logic [INST_WIDTH-1:0] beat_merge;
  logic                  abort;

  assign look_idx = bus.pc[IDX-1:0];
  assign look_tag = bus.pc[M_WIDTH-1:IDX];
  assign look_hit = valid_q[look_idx] && (tag_mem[look_idx] == look_tag);
  assign fill_idx = pc_l_q[IDX-1:0];

  // Flush or loss of enable leaves any non-idle state on the next edge and
  // suppresses a pending line write.
  assign abort = bus.flush || !bus.en;

  // Current instruction register with the active beat's slice replaced by
  // the incoming memory word.
  for (genvar gi = 0; gi < BEATS; gi++) begin : g_beat
    assign beat_merge[gi*M_WIDTH +: M_WIDTH] =
      (beat_q == BEAT_W'(gi)) ? bus.data_in : inst_q[gi*M_WIDTH +: M_WIDTH];
  end

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    inst_d  = inst_q;
    pc_l_d  = pc_l_q;
    valid_d = valid_q;
    wr_en   = 1'b0;

    if (bus.flush) begin
      valid_d = '0;
    end

    case (state_q)
      S_IDLE: begin
        if (bus.en && !bus.flush) begin
          pc_l_d = bus.pc;
          if (look_hit) begin
            inst_d  = data_mem[look_idx];
            state_d = S_DONE;
          end else begin
            beat_d  = '0;
            state_d = S_FETCH;
          end
        end
      end

      S_FETCH: begin
        if (abort) begin
          beat_d  = '0;
          state_d = S_IDLE;
        end else if (bus.mem_ready) begin
          inst_d = beat_merge;
          if (beat_q == BEAT_LAST) begin
            beat_d  = '0;
            state_d = S_FILL;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end

      S_FILL: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          wr_en             = 1'b1;
          valid_d[fill_idx] = 1'b1;
          state_d           = S_DONE;
        end
      end

      S_DONE: begin
        if (abort || bus.inst_ack) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      beat_q  <= '0;
      inst_q  <= '0;
      pc_l_q  <= '0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      inst_q  <= inst_d;
      pc_l_q  <= pc_l_d;
      valid_q <= valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_mem[fill_idx]  <= pc_l_q[M_WIDTH-1:IDX];
      data_mem[fill_idx] <= inst_q;
    end
  end

  // Outputs decode directly from the state register, so an asynchronous
  // reset drops mem_req and inst_valid without waiting for a clock edge.
  assign bus.mem_req    = (state_q == S_FETCH);
  assign bus.busy       = (state_q == S_FETCH) || (state_q == S_FILL);
  assign bus.inst_valid = (state_q == S_DONE);
  assign bus.inst_out   = inst_q;
  assign bus.addr       = (state_q == S_FETCH) ? (pc_l_q + M_WIDTH'(beat_q)) : bus.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit
// Scoreboard bench for fetch_unit. The driver computes each expected
// instruction and the memory addresses it should read from a simple model
// (a memory array plus a per-line record of which pc is cached), and pushes
// them into queues. A negedge monitor pops and compares whenever the DUT
// reads memory or hands an instruction to decode.
// ---------------------------------------------------------------------------
module tb_fetch_unit;

  localparam int MW    = 8;
  localparam int IW    = 16;
  localparam int CC    = 8;
  localparam int BEATS = IW / MW;
  localparam int MSZ   = 1 << MW;

  logic clk = 1'b0;
  logic rst;

  fetch_unit_if #(.M_WIDTH(MW), .INST_WIDTH(IW)) bus ();

  fetch_unit #(
    .M_WIDTH(MW),
    .INST_WIDTH(IW),
    .CELL_CNT(CC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  logic [MW-1:0] mem [MSZ];
  assign bus.data_in = mem[bus.addr];

  // Reference cache: which pc each line holds and the instruction captured.
  bit            m_valid [CC];
  logic [MW-1:0] m_pc    [CC];
  logic [IW-1:0] m_data  [CC];

  logic [IW-1:0] exp_q  [$];
  logic [MW-1:0] addr_q [$];

  int compared   = 0;
  int mismatched = 0;
  int req_cycles, stall_cycles, busy_cycles;
  int mode, stall_ctr;

  function automatic void check(string name, longint actual, longint expected);
    compared++;
    if (actual != expected) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, actual, expected);
    end
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < CC; i++) m_valid[i] = 1'b0;
  endfunction

  function automatic bit model_hit(logic [MW-1:0] p);
    int idx = int'(p) % CC;
    return m_valid[idx] && (m_pc[idx] == p);
  endfunction

  // Memory responder: 0 = always ready, 1 = random stalls,
  // 2 = exactly two wait cycles before each beat.
  always @(posedge clk) begin
    #1;
    if (mode == 0) begin
      bus.mem_ready = 1'b1;
    end else if (mode == 1) begin
      bus.mem_ready = ($urandom % 3) != 0;
    end else begin
      if (bus.mem_req && stall_ctr == 2) begin
        bus.mem_ready = 1'b1;
        stall_ctr     = 0;
      end else begin
        bus.mem_ready = 1'b0;
        stall_ctr     = bus.mem_req ? stall_ctr + 1 : 0;
      end
    end
  end

  // Monitor
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.mem_req) req_cycles++;
      if (bus.mem_req && !bus.mem_ready) stall_cycles++;
      if (bus.busy) busy_cycles++;
      if (bus.mem_req && bus.mem_ready) begin
        if (addr_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL unexpected_mem_read: got addr=0x%0h, required no read", bus.addr);
        end else begin
          check("mem_addr", bus.addr, addr_q.pop_front());
        end
      end
      if (bus.inst_valid && bus.inst_ack) begin
        if (exp_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL unexpected_inst: got inst_out=0x%0h, required none", bus.inst_out);
        end else begin
          logic [IW-1:0] e;
          e = exp_q.pop_front();
          $display("txn inst_out=0x%0h expected=0x%0h", bus.inst_out, e);
          check("inst_out", bus.inst_out, e);
        end
      end
    end
  end

  task automatic do_fetch(input logic [MW-1:0] p, input int ack_delay);
    logic [IW-1:0] e;
    logic [MW-1:0] a;
    bit            hit;
    int            idx, lat, exp_lat;
    idx = int'(p) % CC;
    hit = model_hit(p);
    if (hit) begin
      e = m_data[idx];
    end else begin
      for (int i = 0; i < BEATS; i++) begin
        a = p + MW'(i);
        e[i*MW +: MW] = mem[a];
        addr_q.push_back(a);
      end
    end
    exp_q.push_back(e);

    @(posedge clk); #1;
    req_cycles   = 0;
    stall_cycles = 0;
    busy_cycles  = 0;
    bus.en       = 1'b1;
    bus.pc       = p;
    bus.inst_ack = (ack_delay == 0);
    lat = 0;
    while (!bus.inst_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!bus.inst_valid) begin
      compared++;
      mismatched++;
      $display("FAIL fetch_timeout: got no inst_valid after %0d cycles, required completion (pc=0x%0h)", lat, p);
      bus.en       = 1'b0;
      bus.inst_ack = 1'b1;
      return;
    end
    exp_lat = hit ? 1 : BEATS + 2 + stall_cycles;
    check("latency", lat, exp_lat);
    check("missed", req_cycles > 0, !hit);
    check("busy_cycles", busy_cycles, hit ? 0 : BEATS + stall_cycles + 1);

    for (int k = 0; k < ack_delay; k++) begin
      bus.pc = MW'($urandom);
      @(posedge clk); #1;
      check("valid_hold", bus.inst_valid, 1);
    end
    bus.inst_ack = 1'b1;
    @(posedge clk); #1;
    bus.en = 1'b0;
    check("valid_after_ack", bus.inst_valid, 0);

    if (!hit) begin
      m_valid[idx] = 1'b1;
      m_pc[idx]    = p;
      m_data[idx]  = e;
    end
  endtask

  task automatic flush_pulse();
    @(posedge clk); #1;
    bus.flush = 1'b1;
    bus.en    = 1'b1;
    bus.pc    = MW'($urandom);
    @(posedge clk); #1;
    bus.flush = 1'b0;
    bus.en    = 1'b0;
    check("flush_no_lookup_busy", bus.busy, 0);
    check("flush_no_lookup_valid", bus.inst_valid, 0);
    model_clear();
  endtask

  // kind 0: drop en during beat 1; kind 1: flush during beat 1;
  // kind 2: asynchronous reset in the middle of beat 1.
  task automatic abort_fetch(input int kind);
    logic [MW-1:0] p;
    int tries = 0;
    mode = 0;
    p = MW'($urandom);
    while (model_hit(p) && tries < 50) begin
      p = MW'($urandom);
      tries++;
    end
    addr_q.push_back(p);
    if (kind != 2) addr_q.push_back(p + MW'(1));

    @(posedge clk); #1;
    bus.en = 1'b1;
    bus.pc = p;
    @(posedge clk); #1;
    check("abort_in_fetch", bus.mem_req, 1);
    @(posedge clk); #1;
    if (kind == 0) begin
      bus.en = 1'b0;
      @(posedge clk); #1;
    end else if (kind == 1) begin
      bus.flush = 1'b1;
      @(posedge clk); #1;
      bus.flush = 1'b0;
      bus.en    = 1'b0;
      model_clear();
    end else begin
      #2;
      rst = 1'b1;
      #1;
      check("async_rst_inst_out", bus.inst_out, 0);
      bus.en = 1'b0;
      model_clear();
    end
    check("abort_mem_req", bus.mem_req, 0);
    check("abort_busy", bus.busy, 0);
    check("abort_inst_valid", bus.inst_valid, 0);
    if (kind == 2) begin
      @(negedge clk);
      rst = 1'b0;
    end
    do_fetch(p, 0);
  endtask

  initial begin
    rst           = 1'b1;
    bus.en        = 1'b0;
    bus.flush     = 1'b0;
    bus.pc        = 8'h5A;
    bus.inst_ack  = 1'b1;
    bus.mem_ready = 1'b0;
    mode          = 0;
    stall_ctr     = 0;
    for (int i = 0; i < MSZ; i++) mem[i] = MW'($urandom);
    model_clear();

    #3;
    check("rst_mem_req", bus.mem_req, 0);
    check("rst_inst_valid", bus.inst_valid, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_inst_out", bus.inst_out, 0);
    check("rst_addr", bus.addr, 8'h5A);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Cold miss, hit, wrap with stalls, conflict.
    mem[8'h10] = 8'h34;
    mem[8'h11] = 8'h12;
    do_fetch(8'h10, 0);
    do_fetch(8'h10, 0);
    mode = 2;
    do_fetch(8'hFF, 0);
    mode = 0;
    do_fetch(8'h18, 0);
    do_fetch(8'h10, 2);

    // Flush then refetch, then the abort / reset cases.
    flush_pulse();
    do_fetch(8'h10, 0);
    abort_fetch(0);
    abort_fetch(1);
    abort_fetch(2);

    for (int t = 0; t < 160; t++) begin
      int r;
      r = $urandom % 20;
      if (r == 0) begin
        flush_pulse();
      end else if (r == 1) begin
        abort_fetch($urandom % 3);
      end else begin
        logic [MW-1:0] p;
        if ($urandom % 8 == 0) mem[$urandom % MSZ] = MW'($urandom);
        mode = $urandom % 3;
        p = MW'($urandom_range(0, 23)) + (($urandom % 2) ? MW'(8'hF0) : MW'(0));
        do_fetch(p, ($urandom % 3 == 0) ? $urandom_range(1, 3) : 0);
      end
    end

    repeat (4) @(posedge clk);
    check("exp_q_left", exp_q.size(), 0);
    check("addr_q_left", addr_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
